// File: rtl/hzd_scoreboard.sv
// Hazard unit: per-register scoreboard for multi-cycle producers,
// multi-cycle mispredict flush and wrapping stall/flush event counters.
module hzd_scoreboard #(
    parameter int WIDTH       = 32,
    parameter int INDEX       = 5,
    parameter int LOAD_LAT    = 1,
    parameter int MDU_LAT     = 4,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             idex_valid_in,
    input  logic             idex_reg_write_in,
    input  logic             idex_mem_read_in,
    input  logic             idex_mdu_in,
    input  logic [INDEX-1:0] idex_rd_in,
    input  logic [WIDTH-1:0] idex_pc_in,
    input  logic [INDEX-1:0] ifid_rs1_in,
    input  logic [INDEX-1:0] ifid_rs2_in,
    input  logic             ifid_use_rs1_in,
    input  logic             ifid_use_rs2_in,
    input  logic             branch_in,
    input  logic [WIDTH-1:0] exmem_branch_in,
    output logic             stall_out,
    output logic             flush_out,
    output logic [WIDTH-1:0] stall_count_out,
    output logic [WIDTH-1:0] flush_count_out
);

    localparam int MAXLAT = (LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);
    localparam int FW     = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam int NREG   = 2 ** INDEX;

    localparam logic [CW-1:0] LOAD_INIT  = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] MDU_INIT   = CW'(MDU_LAT - 1);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_DEPTH - 1);

    logic [CW-1:0]    r_cnt [NREG];
    logic [FW-1:0]    r_fcnt;
    logic [WIDTH-1:0] r_stall_cnt;
    logic [WIDTH-1:0] r_flush_cnt;

    logic [CW-1:0]    w_cnt_nxt [NREG];
    logic [CW-1:0]    w_dec;
    logic [CW-1:0]    w_lat;
    logic             w_mis;
    logic             w_flush;
    logic             w_iss;
    logic             w_busy1;
    logic             w_busy2;
    logic             w_stall;

    assign w_mis = idex_valid_in & branch_in
                 & (exmem_branch_in != idex_pc_in);

    // Outputs are forced quiet while reset is held
    assign w_flush = ~rst_in & (w_mis | (r_fcnt != '0));

    assign w_iss = idex_valid_in & idex_reg_write_in
                 & (idex_mem_read_in | idex_mdu_in)
                 & (idex_rd_in != '0) & ~w_flush;

    assign w_lat = idex_mem_read_in ? LOAD_INIT : MDU_INIT;

    always_comb begin
        w_busy1 = (ifid_rs1_in != '0)
                & ((r_cnt[ifid_rs1_in] != '0)
                   | (w_iss & (idex_rd_in == ifid_rs1_in)));
        w_busy2 = (ifid_rs2_in != '0)
                & ((r_cnt[ifid_rs2_in] != '0)
                   | (w_iss & (idex_rd_in == ifid_rs2_in)));
    end

    assign w_stall = ~rst_in & ~w_flush
                   & ((ifid_use_rs1_in & w_busy1)
                      | (ifid_use_rs2_in & w_busy2));

    // A younger write never shortens an older pending result
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NREG; i++) begin
            w_dec = (r_cnt[i] != '0) ? r_cnt[i] - 1'b1 : '0;
            w_cnt_nxt[i] = w_dec;
            if (w_iss && (idex_rd_in == INDEX'(i)) && (w_lat > w_dec))
                w_cnt_nxt[i] = w_lat;
        end
        w_cnt_nxt[0] = '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++)
                r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_fcnt <= '0;
        end else if (w_mis) begin
            r_fcnt <= FLUSH_INIT;
        end else if (r_fcnt != '0) begin
            r_fcnt <= r_fcnt - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_mis)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_out       = w_stall;
    assign flush_out       = w_flush;
    assign stall_count_out = r_stall_cnt;
    assign flush_count_out = r_flush_cnt;

endmodule
